// File: rtl/risc_toy_pkg.sv
// Shared widths, reset address and fetch-entry type for the RISC_TOY fetch stage.
package risc_toy_pkg;

    localparam int unsigned IADDR_W = 30;
    localparam int unsigned INSTR_W = 32;

    localparam logic [IADDR_W-1:0] DEFAULT_RESET_ADDR = '0;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [IADDR_W-1:0] addr;
    } fetch_entry_t;

endpackage

// File: rtl/risc_toy_fetch_hold_buf.sv
// One-entry skid buffer for fetched instructions that decode could not accept yet.
module fetch_hold_buf
    import risc_toy_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clear_i,
    input  logic         load_i,
    input  logic         consume_i,
    input  fetch_entry_t entry_i,
    output logic         valid_o,
    output fetch_entry_t entry_o
);

    logic         valid_q, valid_d;
    fetch_entry_t entry_q, entry_d;

    // Load wins over consume so a consumed entry can be refilled in the same cycle.
    always_comb begin
        valid_d = valid_q;
        entry_d = entry_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            entry_d = entry_i;
        end else if (consume_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            entry_q <= '0;
        end else begin
            valid_q <= valid_d;
            entry_q <= entry_d;
        end
    end

    assign valid_o = valid_q;
    assign entry_o = entry_q;

endmodule

// File: rtl/risc_toy_fetch.sv
// RISC_TOY instruction-fetch stage: PC, instruction-memory request, stall hold buffer and IF/ID register.
module risc_toy_fetch
    import risc_toy_pkg::*;
#(
    parameter logic [IADDR_W-1:0] RESET_ADDR = DEFAULT_RESET_ADDR
) (
    input  logic               CLK,
    input  logic               RST,
    output logic               IREQ,
    output logic [IADDR_W-1:0] IADDR,
    input  logic [INSTR_W-1:0] INSTR,
    input  logic               STALL,
    input  logic               REDIRECT,
    input  logic [31:0]        REDIRECT_PC,
    output logic               ID_valid,
    output logic [INSTR_W-1:0] ID_instr,
    output logic [IADDR_W-1:0] ID_iaddr
);

    logic [IADDR_W-1:0] pc_q, pc_d;
    logic               f2_valid_q, f2_valid_d;
    logic [IADDR_W-1:0] f2_addr_q, f2_addr_d;
    logic               id_valid_q, id_valid_d;
    logic [INSTR_W-1:0] id_instr_q, id_instr_d;
    logic [IADDR_W-1:0] id_iaddr_q, id_iaddr_d;

    logic         hold_valid, hold_next, issue;
    logic         hold_load, hold_consume;
    fetch_entry_t hold_entry, f2_entry, src_entry;
    logic         src_valid;
    logic         unused_rpc_lsb;

    assign unused_rpc_lsb = ^REDIRECT_PC[1:0];
    assign f2_entry       = '{instr: INSTR, addr: f2_addr_q};

    fetch_hold_buf u_hold (
        .clk_i     (CLK),
        .rst_i     (RST),
        .clear_i   (REDIRECT),
        .load_i    (hold_load),
        .consume_i (hold_consume),
        .entry_i   (f2_entry),
        .valid_o   (hold_valid),
        .entry_o   (hold_entry)
    );

    // Issue only if the hold buffer will be empty after this edge; that guarantees room for the new fetch.
    always_comb begin
        hold_next    = 1'b0;
        hold_load    = 1'b0;
        hold_consume = 1'b0;
        src_valid    = hold_valid | f2_valid_q;
        src_entry    = hold_valid ? hold_entry : f2_entry;
        id_valid_d   = id_valid_q;
        id_instr_d   = id_instr_q;
        id_iaddr_d   = id_iaddr_q;

        if (REDIRECT) begin
            hold_next  = 1'b0;
            id_valid_d = 1'b0;
        end else if (STALL) begin
            hold_next = hold_valid | f2_valid_q;
            hold_load = ~hold_valid & f2_valid_q;
        end else begin
            hold_next    = hold_valid & f2_valid_q;
            hold_consume = hold_valid;
            hold_load    = hold_valid & f2_valid_q;
            id_valid_d   = src_valid;
            if (src_valid) begin
                id_instr_d = src_entry.instr;
                id_iaddr_d = src_entry.addr + 1'b1;
            end
        end

        issue      = ~RST & ~REDIRECT & ~hold_next;
        f2_valid_d = issue;
        f2_addr_d  = issue ? pc_q : f2_addr_q;
        if (REDIRECT) begin
            pc_d = REDIRECT_PC[31:2];
        end else if (issue) begin
            pc_d = pc_q + 1'b1;
        end else begin
            pc_d = pc_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pc_q       <= RESET_ADDR;
            f2_valid_q <= 1'b0;
            f2_addr_q  <= '0;
            id_valid_q <= 1'b0;
            id_instr_q <= '0;
            id_iaddr_q <= '0;
        end else begin
            pc_q       <= pc_d;
            f2_valid_q <= f2_valid_d;
            f2_addr_q  <= f2_addr_d;
            id_valid_q <= id_valid_d;
            id_instr_q <= id_instr_d;
            id_iaddr_q <= id_iaddr_d;
        end
    end

    assign IREQ     = issue;
    assign IADDR    = pc_q;
    assign ID_valid = id_valid_q;
    assign ID_instr = id_instr_q;
    assign ID_iaddr = id_iaddr_q;

endmodule
